mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin, burst-locked arbiter that shares the single mem_hw memory port between
//  the dataflow processes (mem_read_U0 = requester 0, mem_write_U0 = requester 1).
//  Grants one requester per burst, passes its beat handshake to the port, counts beats.
//  Per-requester stall detection produces stall_vec, which feeds the deadlock report unit.
// PARAMETERS
//  NUM_REQ      2    number of requesters; bit i of every vector belongs to requester i
//  LEN_W        8    burst length field width; req_len encodes beats-1, max 2^LEN_W beats
//  STALL_LIMIT  256  wait cycles after which a pending requester is flagged stalled
// PORTS
//  clock       in   1              system clock, rising edge
//  reset       in   1              asynchronous, active-low reset
//  req_valid   in   NUM_REQ        burst request pending; held high until req_ready
//  req_len     in   NUM_REQ*LEN_W  beats-1 per requester; slice i = [i*LEN_W +: LEN_W]
//  req_ready   out  NUM_REQ        one-hot pulse: request header accepted this cycle
//  beat_valid  in   NUM_REQ        data beat offered by each requester
//  beat_ready  out  NUM_REQ        beat accepted; only the granted bit can be high
//  grant       out  NUM_REQ        one-hot owner of the port during a burst, else 0
//  mem_valid   out  1              beat valid to the memory port
//  mem_ready   in   1              memory port accepts beat
//  mem_last    out  1              current beat is the final beat of the burst
//  busy        out  1              high while in ST_BURST
//  stall_vec   out  NUM_REQ        requester i waited >= STALL_LIMIT cycles
// BEHAVIOUR
//  Reset: all outputs 0, state ST_IDLE, beat counter 0, rr pointer = requester 0 highest.
//  FSM ST_IDLE:
//   - pick = first set req_valid bit, searching upward from (last_grant+1) mod NUM_REQ.
//   - req_ready = pick, combinational, same cycle.
//   - On the edge, if pick!=0: grant_reg<=pick, len_reg<=req_len slice, cnt<=0,
//     go ST_BURST.
//  FSM ST_BURST:
//   - grant=grant_reg; mem_valid=|(beat_valid & grant_reg);
//     beat_ready=grant_reg & {NUM_REQ{mem_ready}}.
//   - Handshake = mem_valid & mem_ready; on a handshake cnt<=cnt+1.
//   - mem_last = mem_valid & (cnt==len_reg).
//   - On the handshake with cnt==len_reg: last_grant<=grant_reg, go ST_IDLE.
//   - req_ready is 0 throughout; new requests wait in ST_IDLE.
//  Timing: request accepted in IDLE -> first beat possible the next cycle. One dead IDLE
//   cycle between bursts; a burst of N beats with no backpressure takes N+1 cycles.
//  Backpressure: mem_ready=0 or beat_valid=0 holds cnt and grant; no timeout aborts a burst.
//  beat_valid from non-granted requesters is ignored; their beat_ready stays 0.
//  req_len=0 -> 1-beat burst; all-ones -> 2^LEN_W beats; cnt is LEN_W bits, never wraps
//   past len_reg.
//  Stall counters (one per requester, saturating at STALL_LIMIT):
//   - +1 each cycle req_valid[i] & ~req_ready[i].
//   - Cleared on any cycle with req_ready[i] | ~req_valid[i].
//   - stall_vec[i] = (cnt_i == STALL_LIMIT), registered; low the cycle after acceptance.
//  Async reset mid-burst: all outputs drop immediately, burst discarded, rr pointer back to 0.
//  Protocol violation (req_valid dropped before req_ready) is legal input: no grant, no error.
// TESTING
//  1 Hold reset low, drive all inputs 1 -> every output 0. Release -> state ST_IDLE.
//  2 req_valid=01, req_len0=3, beat_valid=01, mem_ready=1 -> req_ready=01 at t0;
//    grant=01 t1..t4; mem_last at t4 only; IDLE at t5.
//  3 After reset, req_valid=11, both len=0, held -> grant order 0,1,0,1;
//    each 1 beat, one IDLE cycle between bursts.
//  4 Burst len=3 with mem_ready=0 for 3 cycles after beat 2 -> cnt holds at 2;
//    mem_last on 4th handshake only; 7 grant cycles total.
//  5 STALL_LIMIT=8, req0 len=15 granted, req1 valid from t1 -> stall_vec[1]=1 from t9;
//    clears the cycle after req_ready[1]; stall_vec[0] stays 0.
//  6 Assert reset at beat 2 of a 4-beat burst for requester 1 -> grant=0 immediately.
//    Release with req_valid=11 -> requester 0 granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin, burst-locked arbiter sharing one memory port
//               between NUM_REQ requesters, with per-requester stall flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int LEN_W       = 8,
    parameter int STALL_LIMIT = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       beat_valid,
    output logic [NUM_REQ-1:0]       beat_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_last,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       stall_vec
);

    localparam int c_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_WAIT_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_grant_idx;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;

    logic [NUM_REQ-1:0]   w_pick;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [LEN_W-1:0]     w_pick_len;
    int                   w_best;
    logic                 w_hs;
    logic                 w_final;

    // Priority distance of requester j is how far it sits above the last grant.
    always_comb begin
        w_pick     = '0;
        w_pick_idx = '0;
        w_pick_len = '0;
        w_best     = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] &&
                (((j + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ) < w_best)) begin
                w_best     = (j + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
                w_pick     = '0;
                w_pick[j]  = 1'b1;
                w_pick_idx = c_IDX_W'(j);
                w_pick_len = req_len[j*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        grant        = '0;
        beat_ready   = '0;
        mem_valid    = 1'b0;
        mem_last     = 1'b0;
        w_hs         = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by reset so nothing is offered while reset is held.
                req_ready = reset ? w_pick : '0;
                if (|w_pick) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                grant      = r_grant;
                mem_valid  = |(beat_valid & r_grant);
                beat_ready = r_grant & {NUM_REQ{mem_ready}};
                mem_last   = mem_valid & (r_cnt == r_len);
                w_hs       = mem_valid & mem_ready;
                w_final    = w_hs & (r_cnt == r_len);
                if (w_final) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_BURST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= c_IDX_W'(NUM_REQ - 1);
            r_len        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                if (|w_pick) begin
                    r_grant     <= w_pick;
                    r_grant_idx <= w_pick_idx;
                    r_len       <= w_pick_len;
                    r_cnt       <= '0;
                end
            end else if (w_final) begin
                r_last_grant <= r_grant_idx;
                r_grant      <= '0;
                r_cnt        <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall
        logic [c_WAIT_W-1:0] r_wait;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_wait <= '0;
            end else if (req_ready[gi] || !req_valid[gi]) begin
                r_wait <= '0;
            end else if (r_wait != c_WAIT_W'(STALL_LIMIT)) begin
                r_wait <= r_wait + 1'b1;
            end
        end

        assign stall_vec[gi] = (r_wait == c_WAIT_W'(STALL_LIMIT));
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench: vector table, directed corner sequences
//               and random traffic against a beats-remaining reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int LEN_W       = 8;
    localparam int STALL_LIMIT = 8;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       beat_valid;
    logic [NUM_REQ-1:0]       beat_ready;
    logic [NUM_REQ-1:0]       grant;
    logic                     mem_valid;
    logic                     mem_ready;
    logic                     mem_last;
    logic                     busy;
    logic [NUM_REQ-1:0]       stall_vec;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner (-1 when idle), beats still owed, last winner, wait ages.
    int m_owner;
    int m_left;
    int m_last;
    int m_wait [NUM_REQ];

    typedef struct {
        bit         rst;
        logic [1:0] rv;
        logic [7:0] len0;
        logic [7:0] len1;
        logic [1:0] bv;
        bit         mr;
        logic [1:0] e_rr;
        logic [1:0] e_g;
        logic [1:0] e_br;
        bit         e_mv;
        bit         e_last;
        bit         e_busy;
    } vec_t;

    vec_t tbl[$];

    mem_port_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .LEN_W       (LEN_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .grant      (grant),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_last   (mem_last),
        .busy       (busy),
        .stall_vec  (stall_vec)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    endtask

    function automatic vec_t mk(input bit rst, input logic [1:0] rv, input logic [7:0] len0,
                                input logic [7:0] len1, input logic [1:0] bv, input bit mr,
                                input logic [1:0] e_rr, input logic [1:0] e_g,
                                input logic [1:0] e_br, input bit e_mv, input bit e_last,
                                input bit e_busy);
        vec_t v;
        v.rst = rst; v.rv = rv; v.len0 = len0; v.len1 = len1; v.bv = bv; v.mr = mr;
        v.e_rr = e_rr; v.e_g = e_g; v.e_br = e_br;
        v.e_mv = e_mv; v.e_last = e_last; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic [1:0] rv, input logic [15:0] len, input logic [1:0] bv,
                         input logic mr);
        req_valid  = rv;
        req_len    = len;
        beat_valid = bv;
        mem_ready  = mr;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(2'b00, 16'h0, 2'b00, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic apply_row(input vec_t v);
        if (v.rst) do_reset();
        drive(v.rv, {v.len1, v.len0}, v.bv, v.mr);
        #1;
        chk("tbl_req_ready",  req_ready,  v.e_rr);
        chk("tbl_grant",      grant,      v.e_g);
        chk("tbl_beat_ready", beat_ready, v.e_br);
        chk("tbl_mem_valid",  mem_valid,  v.e_mv);
        chk("tbl_mem_last",   mem_last,   v.e_last);
        chk("tbl_busy",       busy,       v.e_busy);
        @(negedge clock);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 0;
    endtask

    task automatic model_cycle(output logic [1:0] acc);
        logic [1:0] e_rr, e_g, e_br, e_sv;
        logic       e_mv, e_last, e_busy;
        int         pick;
        e_rr = '0; e_g = '0; e_br = '0; e_sv = '0;
        e_mv = 1'b0; e_last = 1'b0; e_busy = 1'b0;
        pick = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++)
                if (pick < 0 && req_valid[(m_last + k) % NUM_REQ]) pick = (m_last + k) % NUM_REQ;
            if (pick >= 0) e_rr[pick] = 1'b1;
        end else begin
            e_g[m_owner] = 1'b1;
            e_mv   = beat_valid[m_owner];
            e_br   = mem_ready ? e_g : 2'b00;
            e_last = e_mv && (m_left == 1);
            e_busy = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) e_sv[i] = (m_wait[i] >= STALL_LIMIT);
        chk("rand_req_ready",  req_ready,  e_rr);
        chk("rand_grant",      grant,      e_g);
        chk("rand_beat_ready", beat_ready, e_br);
        chk("rand_mem_valid",  mem_valid,  e_mv);
        chk("rand_mem_last",   mem_last,   e_last);
        chk("rand_busy",       busy,       e_busy);
        chk("rand_stall_vec",  stall_vec,  e_sv);
        for (int i = 0; i < NUM_REQ; i++)
            m_wait[i] = (req_valid[i] && !e_rr[i]) ? m_wait[i] + 1 : 0;
        if (m_owner < 0) begin
            if (pick >= 0) begin
                m_owner = pick;
                m_left  = int'(req_len[pick*LEN_W +: LEN_W]) + 1;
            end
        end else if (e_mv && mem_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        acc = e_rr;
    endtask

    initial begin
        logic [1:0] acc;
        int         gcyc;
        int         lcnt;
        bit         last_ok;

        clock = 1'b0;
        reset = 1'b0;
        drive(2'b00, 16'h0, 2'b00, 1'b0);

        // Single burst, 4 beats, no backpressure.
        tbl.push_back(mk(1, 2'b01, 8'd3, 8'd0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 8'd3, 8'd0, 2'b01, 1, 2'b00, 2'b01, 2'b01, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 8'd3, 8'd0, 2'b01, 1, 2'b00, 2'b01, 2'b01, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 8'd3, 8'd0, 2'b01, 1, 2'b00, 2'b01, 2'b01, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 8'd3, 8'd0, 2'b01, 1, 2'b00, 2'b01, 2'b01, 1, 1, 1));
        tbl.push_back(mk(0, 2'b00, 8'd3, 8'd0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        // Requester 1, 2 beats: foreign beats ignored, beat_valid and mem_ready stalls.
        tbl.push_back(mk(1, 2'b10, 8'd0, 8'd1, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 8'd0, 8'd1, 2'b11, 1, 2'b00, 2'b10, 2'b10, 1, 0, 1));
        tbl.push_back(mk(0, 2'b01, 8'd0, 8'd1, 2'b01, 1, 2'b00, 2'b10, 2'b10, 0, 0, 1));
        tbl.push_back(mk(0, 2'b01, 8'd0, 8'd1, 2'b10, 0, 2'b00, 2'b10, 2'b00, 1, 1, 1));
        tbl.push_back(mk(0, 2'b01, 8'd0, 8'd1, 2'b10, 1, 2'b00, 2'b10, 2'b10, 1, 1, 1));
        tbl.push_back(mk(0, 2'b01, 8'd0, 8'd0, 2'b00, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 8'd0, 8'd0, 2'b00, 1, 2'b00, 2'b01, 2'b01, 0, 0, 1));
        tbl.push_back(mk(0, 2'b00, 8'd0, 8'd0, 2'b01, 1, 2'b00, 2'b01, 2'b01, 1, 1, 1));
        tbl.push_back(mk(0, 2'b00, 8'd0, 8'd0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        // Both requesting 1-beat bursts: alternation 0,1,0,1 with an idle cycle between.
        tbl.push_back(mk(1, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b00, 2'b01, 2'b01, 1, 1, 1));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b00, 2'b10, 2'b10, 1, 1, 1));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b00, 2'b01, 2'b01, 1, 1, 1));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 8'd0, 8'd0, 2'b11, 1, 2'b00, 2'b10, 2'b10, 1, 1, 1));

        // Reset held with every input high: all outputs quiet, stall ages frozen.
        drive(2'b11, 16'hFFFF, 2'b11, 1'b1);
        repeat (12) @(negedge clock);
        #1;
        chk("rst_req_ready",  req_ready,  0);
        chk("rst_grant",      grant,      0);
        chk("rst_beat_ready", beat_ready, 0);
        chk("rst_mem_valid",  mem_valid,  0);
        chk("rst_mem_last",   mem_last,   0);
        chk("rst_busy",       busy,       0);
        chk("rst_stall_vec",  stall_vec,  0);
        @(negedge clock);
        drive(2'b00, 16'h0, 2'b00, 1'b0);
        reset = 1'b1;
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_req_ready", req_ready, 0);
        @(negedge clock);
        drive(2'b11, 16'h0, 2'b00, 1'b0);
        #1;
        chk("post_rst_rr_first", req_ready, 2'b01);
        @(negedge clock);

        foreach (tbl[i]) apply_row(tbl[i]);

        // Backpressure: mem_ready low for 3 cycles after the second beat.
        do_reset();
        drive(2'b01, 16'h0003, 2'b01, 1'b1);
        #1;
        chk("bp_req_ready", req_ready, 2'b01);
        @(negedge clock);
        gcyc = 0;
        for (int t = 1; t <= 9; t++) begin
            drive(2'b00, 16'h0003, 2'b01, !(t >= 3 && t <= 5));
            #1;
            if (grant != 2'b00) gcyc++;
            chk("bp_mem_last", mem_last, (t == 7));
            if (t == 4) chk("bp_beat_ready_held", beat_ready, 2'b00);
            @(negedge clock);
        end
        chk("bp_grant_cycles", gcyc, 7);

        // Maximum length burst: all-ones length gives 256 beats, one mem_last.
        do_reset();
        drive(2'b01, 16'h00FF, 2'b01, 1'b1);
        #1;
        chk("max_req_ready", req_ready, 2'b01);
        @(negedge clock);
        drive(2'b00, 16'h00FF, 2'b01, 1'b1);
        gcyc = 0; lcnt = 0; last_ok = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            #1;
            if (grant != 2'b00) gcyc++;
            if (mem_last) begin
                lcnt++;
                last_ok = (gcyc == 256);
            end
            @(negedge clock);
        end
        chk("max_grant_cycles", gcyc, 256);
        chk("max_last_count", lcnt, 1);
        chk("max_last_position", last_ok, 1);

        // Stall detection while requester 0 owns a 16-beat burst.
        do_reset();
        drive(2'b01, 16'h000F, 2'b01, 1'b1);
        #1;
        chk("stall_req_ready0", req_ready, 2'b01);
        @(negedge clock);
        for (int t = 1; t <= 19; t++) begin
            drive((t <= 17) ? 2'b10 : 2'b00, 16'h000F, 2'b01, 1'b1);
            #1;
            chk("stall_vec_seq", stall_vec, (t >= 9 && t <= 17) ? 2 : 0);
            if (t == 17) chk("stall_req_ready1", req_ready, 2'b10);
            @(negedge clock);
        end

        // Asynchronous reset in the middle of a requester-1 burst.
        do_reset();
        drive(2'b10, 16'h0300, 2'b10, 1'b1);
        #1;
        chk("arst_req_ready", req_ready, 2'b10);
        @(negedge clock);
        drive(2'b00, 16'h0300, 2'b10, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        chk("arst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("arst_grant",      grant,      0);
        chk("arst_mem_valid",  mem_valid,  0);
        chk("arst_beat_ready", beat_ready, 0);
        chk("arst_busy",       busy,       0);
        @(negedge clock);
        reset = 1'b1;
        drive(2'b11, 16'h0, 2'b00, 1'b0);
        #1;
        chk("arst_rr_restart", req_ready, 2'b01);
        @(negedge clock);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && acc[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_len[i*LEN_W +: LEN_W] = ($urandom_range(0, 7) == 0) ?
                        LEN_W'($urandom_range(0, 20)) : LEN_W'($urandom_range(0, 3));
                end
                beat_valid[i] = ($urandom_range(0, 3) != 0);
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_cycle(acc);
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
